interp_block: RTL

Sample-rate expander at the input of the CIC interpolator chain. It is the transmit-side counterpart to the decimation block.
- Accepts input samples over a valid/ready handshake into a 2-entry buffer.
- Emits InterpFactor output samples per input sample, one per OutStrobe_i (the output-rate enable).
- Fill samples are zero (zero-stuff mode) or a repeat of the current sample (hold mode).
- The CIC integrator/comb stages downstream consume Data_o/DataVal_o.

---
 rtl/cic_pkg.sv | 23 ++
 rtl/interp_fifo2.sv | 54 +++++
 rtl/interp_block.sv | 103 ++++++++++
 3 files changed

// File: rtl/cic_pkg.sv
// Shared definitions for the CIC interpolation and decimation front ends:
// factor width, the smallest legal factor, the expander state type and the
// factor clamp that maps the raw 0/1 codes onto a factor of one.
package cic_pkg;

    localparam int INTERP_FACTOR_W = 3;
    localparam int MIN_FACTOR      = 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } interp_state_t;

    // Raw factor codes 0 and 1 both mean "one output per input".
    function automatic logic [INTERP_FACTOR_W-1:0] eff_factor(
        input logic [INTERP_FACTOR_W-1:0] raw
    );
        logic [INTERP_FACTOR_W-1:0] minF;
        minF = INTERP_FACTOR_W'(MIN_FACTOR);
        return (raw <= minF) ? minF : raw;
    endfunction

endpackage

// File: rtl/interp_fifo2.sv
// Two-entry sample buffer in front of the interpolation expander.
// Push into a full buffer and pop from an empty one are ignored, so a pop
// and a push landing on an empty buffer in the same cycle stores the push.
module interp_fifo2
    import cic_pkg::*;
#(
    parameter int DataWidth = 18
) (
    input  logic                 Clk_i,
    input  logic                 Rst_i,
    input  logic                 push,
    input  logic [DataWidth-1:0] data,
    input  logic                 pop,
    output logic [1:0]           count,
    output logic [DataWidth-1:0] head
);

    logic [DataWidth-1:0] mem [2];
    logic                 wrPtr;
    logic                 rdPtr;
    logic [1:0]           cnt;
    logic                 doPush;
    logic                 doPop;

    assign doPush = push && (cnt != 2'd2);
    assign doPop  = pop  && (cnt != 2'd0);
    assign count  = cnt;
    assign head   = mem[rdPtr];

    // Storage, pointer and occupancy update; pointers toggle between the two slots.
    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wrPtr  <= 1'b0;
            rdPtr  <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= data;
                wrPtr      <= ~wrPtr;
            end
            if (doPop) begin
                rdPtr <= ~rdPtr;
            end
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/interp_block.sv
// Sample-rate expander feeding the CIC interpolator integrators.
// Each buffered input sample becomes a burst of "factor" output phases, one
// per OutStrobe_i; phase 0 carries the sample, the remaining phases carry
// zero or a repeat of the sample depending on HoldMode_i. Outputs are
// registered, so DataVal_o follows its strobe by one cycle.
module interp_block
    import cic_pkg::*;
#(
    parameter int OutDataWidth   = 18,
    parameter int InterpCntWidth = 7
) (
    input  logic                       Clk_i,
    input  logic                       Rst_i,
    input  logic [INTERP_FACTOR_W-1:0] InterpFactor_i,
    input  logic                       HoldMode_i,
    input  logic [OutDataWidth-1:0]    Data_i,
    input  logic                       DataVal_i,
    output logic                       DataRdy_o,
    input  logic                       OutStrobe_i,
    output logic [OutDataWidth-1:0]    Data_o,
    output logic                       DataVal_o,
    output logic                       Underrun_o
);

    logic [1:0]                        fifoCount;
    logic [OutDataWidth-1:0]           fifoHead;
    logic                              push;
    logic                              pop;
    interp_state_t                     state;
    logic [InterpCntWidth-1:0]         phaseCnt;
    logic [INTERP_FACTOR_W-1:0]        factorLat;
    logic signed [OutDataWidth-1:0]    heldSample;
    logic [INTERP_FACTOR_W-1:0]        effNow;
    logic                              lastPhase;

    // Ready comes from the registered occupancy only, never from the strobe.
    assign DataRdy_o = (fifoCount < 2'd2);
    assign push      = DataVal_i & DataRdy_o;
    assign pop       = OutStrobe_i & (state == IDLE) & (fifoCount != 2'd0);
    assign effNow    = eff_factor(InterpFactor_i);
    assign lastPhase = (phaseCnt == InterpCntWidth'(factorLat - 3'd1));

    interp_fifo2 #(
        .DataWidth (OutDataWidth)
    ) u_fifo (
        .Clk_i (Clk_i),
        .Rst_i (Rst_i),
        .push  (push),
        .data  (Data_i),
        .pop   (pop),
        .count (fifoCount),
        .head  (fifoHead)
    );

    // Phase sequencer: phase 0 pops a sample and latches the factor, fill phases follow.
    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            state      <= IDLE;
            phaseCnt   <= '0;
            factorLat  <= INTERP_FACTOR_W'(MIN_FACTOR);
            heldSample <= '0;
            Data_o     <= '0;
            DataVal_o  <= 1'b0;
            Underrun_o <= 1'b0;
        end else begin
            DataVal_o  <= 1'b0;
            Underrun_o <= 1'b0;
            if (OutStrobe_i) begin
                case (state)
                    IDLE: begin
                        if (fifoCount != 2'd0) begin
                            heldSample <= fifoHead;
                            Data_o     <= fifoHead;
                            DataVal_o  <= 1'b1;
                            factorLat  <= effNow;
                            if (effNow != INTERP_FACTOR_W'(MIN_FACTOR)) begin
                                phaseCnt <= InterpCntWidth'(1);
                                state    <= BURST;
                            end
                        end else begin
                            Underrun_o <= 1'b1;
                        end
                    end
                    BURST: begin
                        Data_o    <= HoldMode_i ? heldSample : '0;
                        DataVal_o <= 1'b1;
                        if (lastPhase) begin
                            phaseCnt <= '0;
                            state    <= IDLE;
                        end else begin
                            phaseCnt <= phaseCnt + 1'b1;
                        end
                    end
                    default: begin
                        phaseCnt <= '0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
